cdc_gray_sync_rx: RTL and testbench
===================================

// Module: cdc_gray_sync_rx
// PURPOSE
// - Receive-side synchroniser for a Gray-coded multi-bit value (FIFO pointer/counter) driven from a foreign domain.
// - N-stage sync chain, registered Gray->binary decode, per-sample change/delta reporting, and Gray-protocol checking
//   (multi-bit hop, backward step). Generalises the fixed 4-bit/2-stage sync-and-decode scheme.
// - Sits in the destination domain next to async FIFOs and cross-domain counters.
// PARAMETERS
// - WIDTH     4  bit width of gray_in / bin_out; legal 2..32
// - STAGES    2  synchroniser flops before decode; legal 2..4 (elaboration error outside range)
// - MONOTONIC 1  1: source is an up-counter, backward step flags dir_err; 0: dir_err tied 0
// PORTS
// - clk         in   1      destination-domain clock
// - rst_n       in   1      asynchronous active-low reset
// - gray_in     in   WIDTH  Gray-coded value, asynchronous to clk
// - err_clr     in   1      synchronous clear of err_sticky
// - bin_out     out  WIDTH  decoded binary value of the last accepted sample
// - valid       out  1      1 once the baseline is seeded (state TRACK)
// - change      out  1      1-cycle pulse: accepted sample differs from previous one
// - delta       out  WIDTH  (bin_new - bin_prev) mod 2^WIDTH; meaningful while change=1, else 0
// - hop_err     out  1      1-cycle pulse: >1 Gray bit changed between consecutive samples
// - dir_err     out  1      1-cycle pulse: delta >= 2^(WIDTH-1) with MONOTONIC=1
// - err_sticky  out  1      set by hop_err|dir_err, cleared by err_clr
// - err_count   out  8      saturating error count (CDC_GRAY_ERR_COUNT_EN only)
// BEHAVIOUR
// - Reset (async assert, sync release by the system): sync chain, prev_gray, bin_out, delta = 0; all flags 0; state WARMUP.
// - Sync chain: sync[0] <= gray_in; sync[i] <= sync[i-1]; s = sync[STAGES-1]. No logic between stages.
// - FSM WARMUP: wcnt counts 0..STAGES-1 after reset release; then SEED. valid=0, no pulses.
// - FSM SEED (1 cycle): prev_gray <= s; bin_out <= gray2bin(s); -> TRACK. No change/err pulse for the baseline.
// - FSM TRACK: each cycle d = s ^ prev_gray; prev_gray <= s; bin_out <= gray2bin(s) (registered).
//   - d == 0: change=0, delta=0.
//   - d != 0: change=1, delta = gray2bin(s) - bin_out (modulo, so wrap 2^WIDTH-1 -> 0 gives delta 1).
//   - popcount(d) > 1: hop_err=1; sample is still accepted (bin_out tracks s).
//   - MONOTONIC=1 and delta[WIDTH-1]=1: dir_err=1. hop_err and dir_err may pulse together.
// - All outputs registered, updated the same cycle; latency gray_in stable -> bin_out/change = STAGES+1 clk edges.
// - err_sticky: set has priority over err_clr in the same cycle; err_clr alone clears it the next edge.
// - Reset mid-operation: everything returns to reset values immediately, warm-up restarts; no pulse on release.
// - The FSM never leaves TRACK except through reset.
// CONFIGURATION
// - CDC_GRAY_ERR_COUNT_EN defined: port err_count present; +1 per cycle with hop_err|dir_err (one count even when both
//   fire), saturates at 255, cleared by err_clr (a simultaneous error wins: count := 1 if it was cleared, else +1).
// - Undefined: err_count port and counter absent; all other behaviour identical.
// STRUCTURE
// - Package cdc_gray_pkg: functions bin2gray/gray2bin (WIDTH-generic via max-width + mask), popcount,
//   typedef enum logic [1:0] {WARMUP, SEED, TRACK} gray_rx_state_e, localparam ERR_CNT_W = 8.
// - Sub-module cdc_sync_chain #(WIDTH, STAGES): pure flop chain with async active-low reset; reused by other CDC blocks.
// - Top holds FSM, decode/delta/check registers, error logic.
// TESTING
// - Reset release, gray_in held 4'b0110 (bin 4): valid rises after STAGES+1 edges, bin_out=4, no change/err pulse.
// - Up-count 0..15 and wrap to 0, one step per 4 clk: 16 change pulses each delta=1, 15->0 delta=1, no errors.
// - Jump gray 4'b0000 -> 4'b0011 (bin 0->2) in TRACK: hop_err=1 one cycle, err_sticky=1, bin_out=2, delta=2.
// - MONOTONIC=1, bin 5 -> 4 (gray 0111 -> 0110): dir_err=1, delta=15, hop_err=0; MONOTONIC=0: dir_err stays 0.
// - err_clr asserted same cycle as new hop_err: err_sticky stays 1; err_clr next cycle alone: err_sticky -> 0.
// - Reset pulse mid-count, WIDTH=8 STAGES=3: outputs zero at once, valid after 4 edges; with CDC_GRAY_ERR_COUNT_EN,
//   300 forced hops -> err_count=255.

Source files
------------

// File: rtl/cdc_gray_pkg.sv
// Shared definitions for the Gray-code receive synchroniser.
// Contents:
//   gray_rx_state_e  receiver FSM states (WARMUP, SEED, TRACK)
//   ERR_CNT_W        width of the optional saturating error counter
//   bin2gray/gray2bin  width-generic conversions; operands are carried in
//                      32 bits and masked to the active width w
//   popcount         number of set bits in a 32-bit word
package cdc_gray_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    SEED   = 2'd1,
    TRACK  = 2'd2
  } gray_rx_state_e;

  localparam int ERR_CNT_W = 8;

  function automatic logic [31:0] width_mask(input int unsigned w);
    logic [31:0] m;
    if (w >= 32) m = '1;
    else         m = (32'd1 << w) - 32'd1;
    return m;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned w);
    logic [31:0] bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; masking
  // first keeps bits beyond the active width from leaking into the result.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned w);
    logic [31:0] gm;
    logic [31:0] b;
    gm = g & width_mask(w);
    b = '0;
    b[31] = gm[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ gm[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/cdc_sync_chain.sv
// Plain multi-flop synchroniser chain, no logic between stages.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears every stage
//   d_i    asynchronous input word
//   q_o    output of the last stage
module cdc_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_gray_sync_rx.sv
// Receive-side synchroniser for a Gray-coded counter/pointer from a foreign
// clock domain. Synchronises, decodes to binary (registered), reports
// per-sample change and modular delta, and flags Gray protocol violations.
// Optional feature macro: CDC_GRAY_ERR_COUNT_EN adds the err_count port and
// an 8-bit saturating error counter.
// Ports:
//   clk, rst_n   destination clock, asynchronous active-low reset
//   gray_in      Gray value from the source domain
//   err_clr      synchronous clear of err_sticky (and err_count)
//   bin_out      decoded value of the last accepted sample
//   valid        high once the baseline sample is taken
//   change       1-cycle pulse when the accepted sample moved
//   delta        (new - previous) mod 2^WIDTH while change=1, else 0
//   hop_err      1-cycle pulse: more than one Gray bit flipped
//   dir_err      1-cycle pulse: backward step (MONOTONIC=1 only)
//   err_sticky   latched error flag
//   err_count    saturating error count (macro builds only)
//   dbg_state    current FSM state for observation
// Handshake: none; gray_in is free-running and every clk samples it. All
// outputs are registered and update on the same edge.
module cdc_gray_sync_rx
  import cdc_gray_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter bit MONOTONIC = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 valid,
  output logic                 change,
  output logic [WIDTH-1:0]     delta,
  output logic                 hop_err,
  output logic                 dir_err,
  output logic                 err_sticky,
`ifdef CDC_GRAY_ERR_COUNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic [1:0]           dbg_state
);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("cdc_gray_sync_rx: STAGES must be 2..4");
  end
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("cdc_gray_sync_rx: WIDTH must be 2..32");
  end

  logic [WIDTH-1:0] s;

  cdc_sync_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gray_in),
    .q_o   (s)
  );

  gray_rx_state_e   state_q, state_d;
  logic [1:0]       wcnt_q, wcnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             valid_q, valid_d;
  logic             change_q, change_d;
  logic             hop_q, hop_d;
  logic             dir_q, dir_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] s_bin;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] gdiff;
  logic             err_now;

  assign s_bin = WIDTH'(gray2bin(32'(s), WIDTH));
  assign diff  = s_bin - bin_q;   // modular: 2^WIDTH-1 -> 0 gives 1
  assign gdiff = s ^ prev_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    prev_d   = prev_q;
    bin_d    = bin_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    delta_d  = '0;
    hop_d    = 1'b0;
    dir_d    = 1'b0;
    case (state_q)
      WARMUP: begin
        // Let the chain fill with post-reset samples before trusting s.
        if (wcnt_q == 2'(STAGES - 1)) state_d = SEED;
        else                          wcnt_d  = wcnt_q + 2'd1;
      end
      SEED: begin
        // Baseline only: no change or error reported for this sample.
        prev_d  = s;
        bin_d   = s_bin;
        valid_d = 1'b1;
        state_d = TRACK;
      end
      TRACK: begin
        prev_d = s;
        bin_d  = s_bin;
        if (gdiff != '0) begin
          change_d = 1'b1;
          delta_d  = diff;
          hop_d    = popcount(32'(gdiff)) > 6'd1;
          dir_d    = MONOTONIC && diff[WIDTH-1];
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  assign err_now = hop_d | dir_d;

  // A new error beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (err_now)      sticky_d = 1'b1;
    else if (err_clr) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WARMUP;
      wcnt_q   <= '0;
      prev_q   <= '0;
      bin_q    <= '0;
      delta_q  <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      hop_q    <= 1'b0;
      dir_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      prev_q   <= prev_d;
      bin_q    <= bin_d;
      delta_q  <= delta_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      hop_q    <= hop_d;
      dir_q    <= dir_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef CDC_GRAY_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // One count per erroring cycle even if hop and dir fire together.
  always_comb begin
    cnt_d = cnt_q;
    if (err_now) begin
      if (err_clr)          cnt_d = ERR_CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
    end else if (err_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

  assign bin_out    = bin_q;
  assign valid      = valid_q;
  assign change     = change_q;
  assign delta      = delta_q;
  assign hop_err    = hop_q;
  assign dir_err    = dir_q;
  assign err_sticky = sticky_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cdc_gray_sync_rx.sv
module tb_cdc_gray_sync_rx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: WIDTH=4 STAGES=2 MONOTONIC=1
  logic       rst_a_n;
  logic [3:0] gray_a;
  logic       clr_a;
  logic [3:0] bin_a, delta_a;
  logic       valid_a, change_a, hop_a, dir_a, sticky_a;
  logic [1:0] st_a;

  // DUT B: WIDTH=8 STAGES=3 MONOTONIC=0
  logic       rst_b_n;
  logic [7:0] gray_b;
  logic       clr_b;
  logic [7:0] bin_b, delta_b;
  logic       valid_b, change_b, hop_b, dir_b, sticky_b;
  logic [1:0] st_b;
`ifdef CDC_GRAY_ERR_COUNT_EN
  logic [7:0] cnt_a, cnt_b;
`endif

  cdc_gray_sync_rx #(.WIDTH(4), .STAGES(2), .MONOTONIC(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .gray_in(gray_a), .err_clr(clr_a),
    .bin_out(bin_a), .valid(valid_a), .change(change_a), .delta(delta_a),
    .hop_err(hop_a), .dir_err(dir_a), .err_sticky(sticky_a),
`ifdef CDC_GRAY_ERR_COUNT_EN
    .err_count(cnt_a),
`endif
    .dbg_state(st_a)
  );

  cdc_gray_sync_rx #(.WIDTH(8), .STAGES(3), .MONOTONIC(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .gray_in(gray_b), .err_clr(clr_b),
    .bin_out(bin_b), .valid(valid_b), .change(change_b), .delta(delta_b),
    .hop_err(hop_b), .dir_err(dir_b), .err_sticky(sticky_b),
`ifdef CDC_GRAY_ERR_COUNT_EN
    .err_count(cnt_b),
`endif
    .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] g8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] e;
    rst_a_n = 1'b0; gray_a = 4'b0110; clr_a = 1'b0;
    rst_b_n = 1'b0; gray_b = 8'h00;   clr_b = 1'b0;
    wait_n(3);
    chk("a_rst_bin",    32'(bin_a), 0);
    chk("a_rst_valid",  32'(valid_a), 0);
    chk("a_rst_change", 32'(change_a), 0);
    chk("a_rst_delta",  32'(delta_a), 0);
    chk("a_rst_sticky", 32'(sticky_a), 0);
    chk("a_rst_state",  32'(st_a), 0);

    // Release with gray 0110 (bin 4): valid after 3 edges, no pulses.
    rst_a_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wait_n(1);
      chk("a_warm_valid", 32'(valid_a), (i == 3) ? 1 : 0);
      chk("a_warm_change", 32'(change_a), 0);
      chk("a_warm_hop", 32'(hop_a), 0);
    end
    chk("a_seed_bin", 32'(bin_a), 4);
    chk("a_seed_state", 32'(st_a), 2);

    // 4 -> 0 via gray 0110 -> 0000: two bits and backward, both flags.
    gray_a = 4'b0000;
    wait_n(2);
    chk("a_hd_pre_change", 32'(change_a), 0);
    wait_n(1);
    chk("a_hd_change", 32'(change_a), 1);
    chk("a_hd_delta",  32'(delta_a), 12);
    chk("a_hd_hop",    32'(hop_a), 1);
    chk("a_hd_dir",    32'(dir_a), 1);
    chk("a_hd_bin",    32'(bin_a), 0);
    chk("a_hd_sticky", 32'(sticky_a), 1);
    wait_n(1);
    chk("a_hd_hop_off", 32'(hop_a), 0);
    chk("a_hd_dir_off", 32'(dir_a), 0);
    chk("a_hd_chg_off", 32'(change_a), 0);
    clr_a = 1'b1;
    wait_n(1);
    clr_a = 1'b0;
    chk("a_clr1_sticky", 32'(sticky_a), 0);

    // Up-count 1..15 then wrap to 0, one step per 4 clocks.
    for (int v = 1; v <= 16; v++) begin
      e = 4'(v);
      exp_q.push_back(e);
      gray_a = 4'(g8(8'(e)));
      wait_n(3);
      chk("a_up_change", 32'(change_a), 1);
      chk("a_up_delta",  32'(delta_a), 1);
      chk("a_up_hop",    32'(hop_a), 0);
      chk("a_up_dir",    32'(dir_a), 0);
      chk("a_up_bin",    32'(bin_a), 32'(exp_q.pop_front()));
      wait_n(1);
      chk("a_up_chg_off", 32'(change_a), 0);
    end
    chk("a_up_sticky", 32'(sticky_a), 0);

    // Jump gray 0000 -> 0011 (bin 0 -> 2).
    gray_a = 4'b0011;
    wait_n(3);
    chk("a_hop_hop",    32'(hop_a), 1);
    chk("a_hop_dir",    32'(dir_a), 0);
    chk("a_hop_bin",    32'(bin_a), 2);
    chk("a_hop_delta",  32'(delta_a), 2);
    chk("a_hop_sticky", 32'(sticky_a), 1);
    wait_n(1);
    chk("a_hop_off",    32'(hop_a), 0);
    chk("a_hop_stick2", 32'(sticky_a), 1);
    clr_a = 1'b1;
    wait_n(1);
    clr_a = 1'b0;
    chk("a_clr2_sticky", 32'(sticky_a), 0);

    // 2 -> 5 (gray 0011 -> 0111), legal forward step of 3.
    gray_a = 4'b0111;
    wait_n(3);
    chk("a_fwd_delta", 32'(delta_a), 3);
    chk("a_fwd_err",   32'({hop_a, dir_a}), 0);
    chk("a_fwd_bin",   32'(bin_a), 5);
    // 5 -> 4 (gray 0111 -> 0110): backward single-bit step.
    gray_a = 4'b0110;
    wait_n(3);
    chk("a_dir_dir",    32'(dir_a), 1);
    chk("a_dir_hop",    32'(hop_a), 0);
    chk("a_dir_delta",  32'(delta_a), 15);
    chk("a_dir_bin",    32'(bin_a), 4);
    chk("a_dir_sticky", 32'(sticky_a), 1);
    clr_a = 1'b1;
    wait_n(1);
    clr_a = 1'b0;
    chk("a_clr3_sticky", 32'(sticky_a), 0);
    chk("a_clr3_dir",    32'(dir_a), 0);

    // err_clr on the same edge that registers a hop: set wins.
    gray_a = 4'b0101;   // bin 6, two gray bits changed
    wait_n(2);
    clr_a = 1'b1;
    wait_n(1);
    chk("a_pri_hop",    32'(hop_a), 1);
    chk("a_pri_sticky", 32'(sticky_a), 1);
    chk("a_pri_bin",    32'(bin_a), 6);
    wait_n(1);
    clr_a = 1'b0;
    chk("a_pri_clr_sticky", 32'(sticky_a), 0);
    chk("a_pri_clr_hop",    32'(hop_a), 0);

    // ---------------- DUT B: WIDTH=8 STAGES=3 MONOTONIC=0 ----------------
    rst_b_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_n(1);
      chk("b_warm_valid", 32'(valid_b), (i == 4) ? 1 : 0);
      chk("b_warm_change", 32'(change_b), 0);
    end
    for (int v = 1; v <= 3; v++) begin
      gray_b = g8(8'(v));
      wait_n(4);
      chk("b_up_bin",   32'(bin_b), 32'(v));
      chk("b_up_delta", 32'(delta_b), 1);
    end
    // 3 -> 2: backward, but direction checking is disabled here.
    gray_b = g8(8'd2);
    wait_n(4);
    chk("b_back_change", 32'(change_b), 1);
    chk("b_back_delta",  32'(delta_b), 8'hff);
    chk("b_back_dir",    32'(dir_b), 0);
    chk("b_back_hop",    32'(hop_b), 0);
    chk("b_back_sticky", 32'(sticky_b), 0);

    // Reset mid-count while a new value is in flight.
    gray_b = g8(8'd3);
    wait_n(1);
    #1 rst_b_n = 1'b0;
    #1;
    chk("b_mrst_bin",   32'(bin_b), 0);
    chk("b_mrst_valid", 32'(valid_b), 0);
    chk("b_mrst_state", 32'(st_b), 0);
    wait_n(2);
    rst_b_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_n(1);
      chk("b_rewarm_valid", 32'(valid_b), (i == 4) ? 1 : 0);
      chk("b_rewarm_change", 32'(change_b), 0);
      chk("b_rewarm_hop", 32'(hop_b), 0);
    end
    chk("b_rewarm_bin", 32'(bin_b), 3);

`ifdef CDC_GRAY_ERR_COUNT_EN
    chk("b_cnt_zero", 32'(cnt_b), 0);
    for (int i = 0; i < 300; i++) begin
      gray_b = (i % 2 == 0) ? 8'h00 : 8'h03;
      wait_n(1);
    end
    wait_n(5);
    chk("b_cnt_sat", 32'(cnt_b), 255);
    chk("b_cnt_sticky", 32'(sticky_b), 1);
    clr_b = 1'b1;
    wait_n(1);
    clr_b = 1'b0;
    chk("b_cnt_clr", 32'(cnt_b), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
